// File: rtl/rng_axi_fetcher.sv
// AXI4-Lite read initiator draining the RNG peripheral into a small sample FIFO.
// Optional RNG_FETCH_DEDUP_EN drops samples equal to the last pushed one and adds dup_cnt_o.

package ariane_axi;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 10;

    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;

    typedef struct packed {
        id_t         id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } aw_chan_t;

    typedef struct packed {
        data_t       data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        id_t         id;
        logic [1:0]  resp;
        logic        user;
    } b_chan_t;

    typedef struct packed {
        id_t         id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } ar_chan_t;

    typedef struct packed {
        id_t         id;
        data_t       data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;
endpackage

module rng_axi_fetcher #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned POLL_GAP       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output ariane_axi::req_t  axi_req_o,
    input  ariane_axi::resp_t axi_resp_i,
    output logic [63:0]       rnd_o,
    output logic              rnd_valid_o,
    input  logic              rnd_ready_i,
    output logic [7:0]        err_cnt_o,
    output logic              busy_o
`ifdef RNG_FETCH_DEDUP_EN
    ,
    output logic [7:0]        dup_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GAP_W = $clog2(POLL_GAP) + 1;
    // The IDLE re-check cycle is part of the quiet window, so GAP itself lasts POLL_GAP-1 cycles.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 2);
    localparam logic [3:0] REG_LO     = 4'd12;
    localparam logic [3:0] REG_HI     = 4'd13;
    localparam logic [3:0] REG_STATUS = 4'd14;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ST_AR = 4'd1,
        ST_R  = 4'd2,
        LO_AR = 4'd3,
        LO_R  = 4'd4,
        HI_AR = 4'd5,
        HI_R  = 4'd6,
        PUSH  = 4'd7,
        GAP   = 4'd8
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic [AXI_ADDR_WIDTH-1:0] reg_addr(input logic [3:0] idx);
        return AXI_ADDR_WIDTH'(BASE_ADDR + {57'd0, idx, 3'b000});
    endfunction

    state_e                    state_r;
    logic                      ar_valid_r;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_r;
    logic                      r_ready_r;
    logic                      busy_r;
    logic [31:0]               lo_r;
    logic [31:0]               hi_r;
    logic [7:0]                err_cnt_r;
    logic [GAP_W-1:0]          gap_cnt_r;

    logic [63:0]               fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          cnt_r;

    logic                      ar_hs_s;
    logic                      r_hs_s;
    logic                      r_ok_s;
    logic [31:0]               r_word_s;
    logic                      fifo_full_s;
    logic [63:0]               sample_s;
    logic                      dup_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      unused_s;

    assign ar_hs_s     = ar_valid_r & axi_resp_i.ar_ready;
    assign r_hs_s      = r_ready_r & axi_resp_i.r_valid;
    assign r_ok_s      = (axi_resp_i.r.resp == 2'b00);
    assign r_word_s    = axi_resp_i.r.data[31:0];
    assign fifo_full_s = (cnt_r == CNT_W'(FIFO_DEPTH));
    assign sample_s    = {hi_r, lo_r};
    assign pop_s       = (cnt_r != {CNT_W{1'b0}}) & rnd_ready_i;

    assign unused_s = ^{axi_resp_i.aw_ready, axi_resp_i.w_ready, axi_resp_i.b_valid, axi_resp_i.b,
                        axi_resp_i.r.id, axi_resp_i.r.data[AXI_DATA_WIDTH-1:32],
                        axi_resp_i.r.last, axi_resp_i.r.user};

`ifdef RNG_FETCH_DEDUP_EN
    logic [63:0] last_r;
    logic [7:0]  dup_cnt_r;

    assign dup_s     = (sample_s == last_r);
    assign dup_cnt_o = dup_cnt_r;

    // Remember the last accepted sample and count dropped repeats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_r    <= 64'h0;
            dup_cnt_r <= 8'h00;
        end else if (state_r == PUSH) begin
            if (dup_s) begin
                dup_cnt_r <= sat_inc8(dup_cnt_r);
            end else begin
                last_r <= sample_s;
            end
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // FIFO write strobe: only from PUSH, and only for samples not flagged as repeats.
    always_comb begin
        push_s = 1'b0;
        if (state_r == PUSH) begin
            push_s = ~dup_s;
        end else begin
            push_s = 1'b0;
        end
    end

    // Fetch sequencer: status poll, low word, high word, push; errors and empty polls back off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            ar_valid_r <= 1'b0;
            ar_addr_r  <= {AXI_ADDR_WIDTH{1'b0}};
            r_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            lo_r       <= 32'h0;
            hi_r       <= 32'h0;
            err_cnt_r  <= 8'h00;
            gap_cnt_r  <= {GAP_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (en_i && !fifo_full_s) begin
                        state_r    <= ST_AR;
                        ar_valid_r <= 1'b1;
                        ar_addr_r  <= reg_addr(REG_STATUS);
                        busy_r     <= 1'b1;
                    end
                end
                ST_AR, LO_AR, HI_AR: begin
                    if (ar_hs_s) begin
                        ar_valid_r <= 1'b0;
                        r_ready_r  <= 1'b1;
                        state_r    <= (state_r == ST_AR) ? ST_R :
                                      (state_r == LO_AR) ? LO_R : HI_R;
                    end
                end
                ST_R, LO_R, HI_R: begin
                    if (r_hs_s) begin
                        r_ready_r <= 1'b0;
                        if (!r_ok_s) begin
                            err_cnt_r <= sat_inc8(err_cnt_r);
                            gap_cnt_r <= {GAP_W{1'b0}};
                            state_r   <= GAP;
                        end else if (state_r == ST_R) begin
                            if (r_word_s[0]) begin
                                state_r    <= LO_AR;
                                ar_valid_r <= 1'b1;
                                ar_addr_r  <= reg_addr(REG_LO);
                            end else begin
                                gap_cnt_r <= {GAP_W{1'b0}};
                                state_r   <= GAP;
                            end
                        end else if (state_r == LO_R) begin
                            lo_r       <= r_word_s;
                            state_r    <= HI_AR;
                            ar_valid_r <= 1'b1;
                            ar_addr_r  <= reg_addr(REG_HI);
                        end else begin
                            hi_r    <= r_word_s;
                            state_r <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (dup_s) begin
                        gap_cnt_r <= {GAP_W{1'b0}};
                        state_r   <= GAP;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    ar_valid_r <= 1'b0;
                    r_ready_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Sample FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 64'h0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= sample_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Drive only the read-address fields; everything else on the request stays zero.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.ar.id    = {AXI_ID_WIDTH{1'b0}};
        axi_req_o.ar.addr  = ar_addr_r;
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = 3'b011;
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar.prot  = 3'b000;
        axi_req_o.ar_valid = ar_valid_r;
        axi_req_o.r_ready  = r_ready_r;
    end

    assign rnd_valid_o = (cnt_r != {CNT_W{1'b0}});
    assign rnd_o       = rnd_valid_o ? fifo_mem_r[rd_ptr_r] : 64'h0;
    assign err_cnt_o   = err_cnt_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_rng_axi_fetcher.sv
// Directed bench for rng_axi_fetcher with a single-outstanding AXI-Lite RNG slave model.
// Build with RNG_FETCH_DEDUP_EN defined to also exercise the duplicate filter.

module tb_rng_axi_fetcher;

    localparam logic [63:0] BASE = 64'h0000_0000_4000_1000;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              en_i;
    logic              rnd_ready_i;
    ariane_axi::req_t  req;
    ariane_axi::resp_t resp;
    logic [63:0]       rnd_o;
    logic              rnd_valid_o;
    logic [7:0]        err_cnt_o;
    logic              busy_o;
`ifdef RNG_FETCH_DEDUP_EN
    logic [7:0]        dup_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // slave model knobs
    logic [31:0] status_val = 32'h1;
    logic [31:0] lo_val     = 32'h0;
    logic [31:0] hi_val     = 32'h0;
    int          err_idx    = -1;
    bit          auto_inc   = 1'b0;
    int          stall_left = 0;

    // posedge-sampled handshake history
    bit          ar_hs_q    = 1'b0;
    bit          r_hs_q     = 1'b0;
    logic [63:0] ar_addr_q  = 64'h0;
    int          err_hs_cnt = 0;
    logic [63:0] ar_log[$];

    always #5 clk_i = ~clk_i;

    rng_axi_fetcher #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .POLL_GAP   (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .axi_req_o   (req),
        .axi_resp_i  (resp),
        .rnd_o       (rnd_o),
        .rnd_valid_o (rnd_valid_o),
        .rnd_ready_i (rnd_ready_i),
        .err_cnt_o   (err_cnt_o),
        .busy_o      (busy_o)
`ifdef RNG_FETCH_DEDUP_EN
        ,
        .dup_cnt_o   (dup_cnt_o)
`endif
    );

    always @(posedge clk_i) begin
        ar_hs_q   <= req.ar_valid && resp.ar_ready;
        r_hs_q    <= resp.r_valid && req.r_ready;
        ar_addr_q <= req.ar.addr;
        if (req.ar_valid && resp.ar_ready) ar_log.push_back(req.ar.addr);
        if (resp.r_valid && req.r_ready && resp.r.resp != 2'b00) err_hs_cnt <= err_hs_cnt + 1;
    end

    // RNG slave: one outstanding read, responses built from the accepted address
    initial begin
        bit          pending;
        int          idx;
        logic [31:0] v;
        pending = 1'b0;
        resp    = '0;
        forever begin
            @(negedge clk_i);
            if (r_hs_q) pending = 1'b0;
            if (ar_hs_q) begin
                pending = 1'b1;
                idx = int'((ar_addr_q - BASE) >> 3);
                case (idx)
                    14: v = status_val;
                    12: begin
                        v = lo_val;
                        if (auto_inc) lo_val = lo_val + 32'd1;
                    end
                    13: v = hi_val;
                    default: v = 32'h0;
                endcase
                resp.r.data = {32'hA5A5_A5A5, v};
                resp.r.resp = (idx == err_idx) ? 2'b10 : 2'b00;
                resp.r.last = 1'b1;
            end
            resp.ar_ready = req.ar_valid && !pending && (stall_left == 0);
            if (req.ar_valid && stall_left > 0) stall_left = stall_left - 1;
            resp.r_valid = pending;
        end
    end

    task automatic run_one(input string tag);
        int n;
        en_i = 1'b1;
        n = 0;
        while (!busy_o && n < 20) begin @(negedge clk_i); n++; end
        en_i = 1'b0;
        n = 0;
        while (busy_o && n < 200) begin @(negedge clk_i); n++; end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: busy=%0b required 0", tag, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; en_i = 1'b0; rnd_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({req.ar_valid, req.r_ready, busy_o, rnd_valid_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: arv/rr/busy/rv=%b required 0000",
                     {req.ar_valid, req.r_ready, busy_o, rnd_valid_o});
        end
        vectors++;
        if (rnd_o !== 64'h0 || err_cnt_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: rnd=%h err=%0d required 0/0", rnd_o, err_cnt_o);
        end
        vectors++;
        if (req.aw !== '0 || req.w !== '0 || {req.aw_valid, req.w_valid, req.b_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_tieoff: aw/w/b fields not zero");
        end
`ifdef RNG_FETCH_DEDUP_EN
        vectors++;
        if (dup_cnt_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_dup: dup=%0d required 0", dup_cnt_o);
        end
`endif
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0 || req.ar_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%0b arv=%0b required 0/0", busy_o, req.ar_valid);
        end
    endtask

    task automatic test_sample();
        int n, lat;
        status_val = 32'h1; lo_val = 32'h89ab_cdef; hi_val = 32'h0123_4567;
        ar_log.delete();
        en_i = 1'b1;
        n = 0;
        while (!req.ar_valid && n < 20) begin @(negedge clk_i); n++; end
        en_i = 1'b0;
        vectors++;
        if ({req.ar.size, req.ar.len, req.ar.burst, req.ar.id} !== {3'b011, 8'd0, 2'b01, 10'd0}) begin
            miscompares++;
            $display("FAIL sample_arfields: size=%b len=%0d burst=%b id=%0d required 011/0/01/0",
                     req.ar.size, req.ar.len, req.ar.burst, req.ar.id);
        end
        lat = 0;
        while (!rnd_valid_o && lat < 50) begin @(negedge clk_i); lat++; end
        vectors++;
        if (lat != 7) begin
            miscompares++;
            $display("FAIL sample_latency: %0d cycles required 7", lat);
        end
        vectors++;
        if (rnd_o !== 64'h0123_4567_89ab_cdef) begin
            miscompares++;
            $display("FAIL sample_data: rnd=%h required 0123456789abcdef", rnd_o);
        end
        vectors++;
        if (ar_log.size() != 3) begin
            miscompares++;
            $display("FAIL sample_arcount: %0d ARs required 3", ar_log.size());
        end else if (ar_log[0] !== BASE + 64'h70 || ar_log[1] !== BASE + 64'h60 || ar_log[2] !== BASE + 64'h68) begin
            miscompares++;
            $display("FAIL sample_araddr: %h %h %h required base+70/60/68", ar_log[0], ar_log[1], ar_log[2]);
        end
        rnd_ready_i = 1'b1;
        @(negedge clk_i);
        rnd_ready_i = 1'b0;
        vectors++;
        if (rnd_valid_o !== 1'b0 || rnd_o !== 64'h0) begin
            miscompares++;
            $display("FAIL sample_pop: rv=%0b rnd=%h required 0/0", rnd_valid_o, rnd_o);
        end
    endtask

    task automatic test_status_gap();
        int n, gap;
        status_val = 32'h0;
        ar_log.delete();
        en_i = 1'b1;
        n = 0;
        while (!r_hs_q && n < 20) begin @(negedge clk_i); n++; end
        gap = 0;
        while (!req.ar_valid && gap < 100) begin gap++; @(negedge clk_i); end
        en_i = 1'b0;
        vectors++;
        if (gap != 16) begin
            miscompares++;
            $display("FAIL gap_len: %0d quiet cycles required 16", gap);
        end
        vectors++;
        if (req.ar.addr !== BASE + 64'h70 || ar_log.size() != 1) begin
            miscompares++;
            $display("FAIL gap_repoll: addr=%h ars=%0d required base+70/1", req.ar.addr, ar_log.size());
        end
        n = 0;
        while (busy_o && n < 100) begin @(negedge clk_i); n++; end
        vectors++;
        if (busy_o !== 1'b0 || err_cnt_o !== 8'h00 || rnd_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_end: busy=%0b err=%0d rv=%0b required 0/0/0", busy_o, err_cnt_o, rnd_valid_o);
        end
    endtask

    task automatic test_errors();
        int n, e0;
        status_val = 32'h1; err_idx = 12;
        ar_log.delete();
        run_one("slverr_lo");
        vectors++;
        if (err_cnt_o !== 8'd1 || rnd_valid_o !== 1'b0 || ar_log.size() != 2) begin
            miscompares++;
            $display("FAIL slverr_lo: err=%0d rv=%0b ars=%0d required 1/0/2", err_cnt_o, rnd_valid_o, ar_log.size());
        end
        e0 = err_hs_cnt - 1;
        err_idx = 14;
        en_i = 1'b1;
        n = 0;
        while ((err_hs_cnt - e0) < 300 && n < 8000) begin @(negedge clk_i); n++; end
        en_i = 1'b0;
        n = 0;
        while (busy_o && n < 100) begin @(negedge clk_i); n++; end
        err_idx = -1;
        vectors++;
        if (err_cnt_o !== 8'd255 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_saturate: err=%0d busy=%0b required 255/0", err_cnt_o, busy_o);
        end
    endtask

    task automatic test_stall();
        int cyc, held, n;
        bit stable, quiet, seen;
        logic [63:0] a0;
        status_val = 32'h1; lo_val = 32'h1357_9bdf; hi_val = 32'h2468_ace0;
        ar_log.delete();
        stall_left = 20;
        en_i = 1'b1;
        cyc = 0; held = 0; stable = 1'b1; seen = 1'b0; a0 = 64'h0;
        while (ar_log.size() == 0 && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 5) en_i = 1'b0;
            if (ar_log.size() == 0) begin
                if (req.ar_valid) begin
                    held++;
                    if (!seen) begin seen = 1'b1; a0 = req.ar.addr; end
                    else if (req.ar.addr !== a0) stable = 1'b0;
                end else if (seen) begin
                    stable = 1'b0;
                end
            end
        end
        en_i = 1'b0;
        vectors++;
        if (!stable || held != 21 || a0 !== BASE + 64'h70) begin
            miscompares++;
            $display("FAIL stall_hold: stable=%0b held=%0d addr=%h required 1/21/base+70", stable, held, a0);
        end
        n = 0;
        while (!rnd_valid_o && n < 60) begin @(negedge clk_i); n++; end
        vectors++;
        if (rnd_o !== 64'h2468_ace0_1357_9bdf) begin
            miscompares++;
            $display("FAIL stall_data: rnd=%h required 2468ace013579bdf", rnd_o);
        end
        quiet = 1'b1;
        repeat (30) begin @(negedge clk_i); if (req.ar_valid || busy_o) quiet = 1'b0; end
        vectors++;
        if (!quiet || ar_log.size() != 3) begin
            miscompares++;
            $display("FAIL stall_idle: quiet=%0b ars=%0d required 1/3", quiet, ar_log.size());
        end
        rnd_ready_i = 1'b1;
        @(negedge clk_i);
        rnd_ready_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        int n;
        bit quiet;
        status_val = 32'h1; lo_val = 32'h1000_0000; hi_val = 32'hcafe_0000; auto_inc = 1'b1;
        ar_log.delete();
        en_i = 1'b1;
        n = 0;
        while (ar_log.size() < 12 && n < 300) begin @(negedge clk_i); n++; end
        quiet = 1'b1;
        repeat (60) begin @(negedge clk_i); if (req.ar_valid) quiet = 1'b0; end
        vectors++;
        if (!quiet || ar_log.size() != 12 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_stop: quiet=%0b ars=%0d busy=%0b required 1/12/0", quiet, ar_log.size(), busy_o);
        end
        vectors++;
        if (rnd_valid_o !== 1'b1 || rnd_o !== 64'hcafe_0000_1000_0000) begin
            miscompares++;
            $display("FAIL full_head: rv=%0b rnd=%h required 1/cafe000010000000", rnd_valid_o, rnd_o);
        end
        rnd_ready_i = 1'b1;
        @(negedge clk_i);
        rnd_ready_i = 1'b0;
        n = 0;
        while (ar_log.size() < 15 && n < 100) begin @(negedge clk_i); n++; end
        quiet = 1'b1;
        repeat (60) begin @(negedge clk_i); if (req.ar_valid) quiet = 1'b0; end
        en_i = 1'b0;
        vectors++;
        if (!quiet || ar_log.size() != 15) begin
            miscompares++;
            $display("FAIL full_refill: quiet=%0b ars=%0d required 1/15", quiet, ar_log.size());
        end
        // pop sample 1, leaving 2,3,4
        vectors++;
        if (rnd_o !== 64'hcafe_0000_1000_0001) begin
            miscompares++;
            $display("FAIL full_order: rnd=%h required cafe000010000001", rnd_o);
        end
        rnd_ready_i = 1'b1;
        @(negedge clk_i);
        rnd_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        en_i = 1'b1;
        n = 0;
        while (!req.ar_valid && n < 20) begin @(negedge clk_i); n++; end
        en_i = 1'b0;
        repeat (6) @(negedge clk_i);
        // pop lands on the same edge as the push of sample 5
        rnd_ready_i = 1'b1;
        @(negedge clk_i);
        rnd_ready_i = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            vectors++;
            if (rnd_valid_o !== 1'b1 || rnd_o !== {32'hcafe_0000, 32'h1000_0000 + 32'(i)}) begin
                miscompares++;
                $display("FAIL b2b_entry%0d: rv=%0b rnd=%h required 1/cafe0000%h", i, rnd_valid_o, rnd_o,
                         32'h1000_0000 + 32'(i));
            end
            rnd_ready_i = 1'b1;
            @(negedge clk_i);
            rnd_ready_i = 1'b0;
        end
        vectors++;
        if (rnd_valid_o !== 1'b0 || rnd_o !== 64'h0) begin
            miscompares++;
            $display("FAIL b2b_empty: rv=%0b rnd=%h required 0/0", rnd_valid_o, rnd_o);
        end
        auto_inc = 1'b0;
    endtask

`ifdef RNG_FETCH_DEDUP_EN
    task automatic test_dedup();
        status_val = 32'h1; lo_val = 32'h0bad_f00d; hi_val = 32'h7777_0000;
        run_one("dedup_first");
        run_one("dedup_repeat");
        vectors++;
        if (dup_cnt_o !== 8'd1 || rnd_o !== 64'h7777_0000_0bad_f00d) begin
            miscompares++;
            $display("FAIL dedup_drop: dup=%0d rnd=%h required 1/777700000badf00d", dup_cnt_o, rnd_o);
        end
        rnd_ready_i = 1'b1;
        @(negedge clk_i);
        rnd_ready_i = 1'b0;
        vectors++;
        if (rnd_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL dedup_single: rv=%0b required 0", rnd_valid_o);
        end
        hi_val = 32'h7777_0001;
        run_one("dedup_new");
        vectors++;
        if (rnd_valid_o !== 1'b1 || rnd_o !== 64'h7777_0001_0bad_f00d || dup_cnt_o !== 8'd1) begin
            miscompares++;
            $display("FAIL dedup_next: rv=%0b rnd=%h dup=%0d required 1/777700010badf00d/1",
                     rnd_valid_o, rnd_o, dup_cnt_o);
        end
        rnd_ready_i = 1'b1;
        @(negedge clk_i);
        rnd_ready_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sample();
        test_status_gap();
        test_errors();
        test_stall();
        test_fifo_full();
        test_back_to_back();
`ifdef RNG_FETCH_DEDUP_EN
        test_dedup();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
